// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operation codes, FSM encoding and operand-signedness helpers.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_signed_a(input logic [2:0] f3);
        case (f3)
            F3_MULH, F3_MULHSU, F3_DIV, F3_REM: is_signed_a = 1'b1;
            default:                            is_signed_a = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        case (f3)
            F3_MULH, F3_DIV, F3_REM: is_signed_b = 1'b1;
            default:                 is_signed_b = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter_sign_conv.sv
// Conditional two's-complement negation; the most negative value maps
// onto itself, which is also its correct unsigned magnitude.
module sign_conv #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: one radix-2 shift-add or restoring
// divide step per cycle on operand magnitudes, sign fix-up at the end.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    state_e              state_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     dvs_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2:0]          f3_r;
    logic                sa_r;
    logic                sb_r;
    logic                busy_r;
    logic                done_r;
    logic [XLEN-1:0]     result_r;

    logic                sa_s;
    logic                sb_s;
    logic [XLEN-1:0]     mag_a_s;
    logic [XLEN-1:0]     mag_b_s;
    logic                fast_s;
    logic [XLEN-1:0]     fast_val_s;
    logic [XLEN:0]       sum_s;
    logic [XLEN:0]       trial_s;
    logic [2*XLEN-1:0]   step_s;
    logic [2*XLEN-1:0]   fix_in_s;
    logic                fix_neg_s;
    logic [2*XLEN-1:0]   fixed_s;
    logic [XLEN-1:0]     fix_val_s;

    assign sa_s = is_signed_a(funct3) & op_a[XLEN-1];
    assign sb_s = is_signed_b(funct3) & op_b[XLEN-1];

    sign_conv #(.W(XLEN)) u_conv_a (.x(op_a), .neg(sa_s), .y(mag_a_s));
    sign_conv #(.W(XLEN)) u_conv_b (.x(op_b), .neg(sb_s), .y(mag_b_s));

    // Divide-by-zero and signed-overflow results that bypass iteration.
    always_comb begin
        fast_s     = 1'b0;
        fast_val_s = ZERO;
        if (funct3[2] && (op_b == ZERO)) begin
            fast_s     = 1'b1;
            fast_val_s = funct3[1] ? op_a : ALL_ONES;
        end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (op_a == MIN_NEG) && (op_b == ALL_ONES)) begin
            fast_s     = 1'b1;
            fast_val_s = funct3[1] ? ZERO : op_a;
        end else begin
            fast_s     = 1'b0;
            fast_val_s = ZERO;
        end
    end

    assign sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, dvs_r};
    assign trial_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, dvs_r};

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        step_s = acc_r;
        if (f3_r[2]) begin
            if (!trial_s[XLEN]) begin
                step_s = {trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                step_s = {acc_r[2*XLEN-2:0], 1'b0};
            end
        end else if (acc_r[0]) begin
            step_s = {sum_s, acc_r[XLEN-1:1]};
        end else begin
            step_s = {1'b0, acc_r[2*XLEN-1:1]};
        end
    end

    // Sign fix-up input: full product for multiplies so the high half negates correctly.
    always_comb begin
        fix_in_s  = acc_r;
        fix_neg_s = sa_r ^ sb_r;
        case (f3_r)
            F3_DIV, F3_DIVU: begin
                fix_in_s  = {ZERO, acc_r[XLEN-1:0]};
                fix_neg_s = sa_r ^ sb_r;
            end
            F3_REM, F3_REMU: begin
                fix_in_s  = {ZERO, acc_r[2*XLEN-1:XLEN]};
                fix_neg_s = sa_r;
            end
            default: begin
                fix_in_s  = acc_r;
                fix_neg_s = sa_r ^ sb_r;
            end
        endcase
    end

    sign_conv #(.W(2*XLEN)) u_conv_res (.x(fix_in_s), .neg(fix_neg_s), .y(fixed_s));

    // Low half for MUL and all divides, high half for the MULH variants.
    always_comb begin
        fix_val_s = fixed_s[XLEN-1:0];
        if ((f3_r == F3_MUL) || f3_r[2]) begin
            fix_val_s = fixed_s[XLEN-1:0];
        end else begin
            fix_val_s = fixed_s[2*XLEN-1:XLEN];
        end
    end

    // Control FSM with registered busy/done/result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            acc_r    <= {(2*XLEN){1'b0}};
            dvs_r    <= ZERO;
            cnt_r    <= {CNT_W{1'b0}};
            f3_r     <= 3'b000;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO;
        end else begin
            done_r <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        f3_r   <= funct3;
                        sa_r   <= sa_s;
                        sb_r   <= sb_s;
                        cnt_r  <= {CNT_W{1'b0}};
                        busy_r <= 1'b1;
                        dvs_r  <= funct3[2] ? mag_b_s : mag_a_s;
                        if (fast_s) begin
                            acc_r   <= {ZERO, fast_val_s};
                            state_r <= ST_DONE;
                        end else begin
                            acc_r   <= {ZERO, (funct3[2] ? mag_a_s : mag_b_s)};
                            state_r <= ST_CALC;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(XLEN - 1)) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_FIX: begin
                    acc_r   <= {ZERO, fix_val_s};
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    result_r <= acc_r[XLEN-1:0];
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed RV32M cases, fast paths,
// ignored restart, back-to-back start, mid-operation reset, random ops.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b, output bit fast);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [63:0] p;
        logic [63:0]        up;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        fast = 1'b0;
        case (f3)
            3'b000: begin p = sa64 * sb64; return p[31:0]; end
            3'b001: begin p = sa64 * sb64; return p[63:32]; end
            3'b010: begin p = sa64 * $signed({32'h0, b}); return p[63:32]; end
            3'b011: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            default: begin
                if (b == 32'h0) begin
                    fast = 1'b1;
                    return f3[1] ? a : 32'hFFFF_FFFF;
                end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    fast = 1'b1;
                    return f3[1] ? 32'h0 : a;
                end else if (f3[0]) begin
                    return f3[1] ? (a % b) : (a / b);
                end else begin
                    return f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
                end
            end
        endcase
    endfunction

    // Drive one request (caller is #1 after an edge), then wait for done and score it.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int lat,
                          input int poke, input bit tail);
        exp_t e;
        exp_t got_e;
        int   n;
        bit   seen;
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        e.res  = res;
        e.lat  = lat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        check_val({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
        seen = 1'b0;
        for (n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == poke) begin
                start  = 1'b1;
                funct3 = 3'b101;
                op_a   = 32'd100;
                op_b   = 32'd7;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        got_e = exp_q.pop_front();
        check_val({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            check_val({tag, "_latency"}, n, got_e.lat);
            check_val({tag, "_result"}, result, got_e.res);
            check_val({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
        end
        if (tail) begin
            @(posedge clk);
            #1;
            check_val({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
            check_val({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
            check_val({tag, "_result_held"}, result, got_e.res);
        end
    endtask

    initial begin
        bit          fast;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rexp;

        reset  = 1'b0;
        start  = 1'b0;
        funct3 = 3'b000;
        op_a   = 32'h0;
        op_b   = 32'h0;
        #12;
        check_val("reset_busy", {31'b0, busy}, 32'd0);
        check_val("reset_done", {31'b0, done}, 32'd0);
        check_val("reset_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, 1'b1);
        run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, 1'b1);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, 1'b1);
        run_op("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, 0, 1'b1);
        run_op("div_poke", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 10, 1'b1);
        run_op("rem_-7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0, 1'b1);
        run_op("divu_b2b", 3'b101, 32'd100, 32'd7, 32'd14, 34, 0, 1'b0);
        run_op("remu_b2b", 3'b111, 32'd100, 32'd7, 32'd2, 34, 0, 1'b1);
        run_op("div_by0", 3'b100, 32'd5, 32'h0, 32'hFFFF_FFFF, 1, 0, 1'b1);
        run_op("remu_by0", 3'b111, 32'd5, 32'h0, 32'd5, 1, 0, 1'b1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            rf3  = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            rexp = model(rf3, ra, rb, fast);
            run_op("random", rf3, ra, rb, rexp, fast ? 1 : 34, 0, 1'b1);
        end

        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd9;
        op_b   = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_val("midrst_busy", {31'b0, busy}, 32'd0);
        check_val("midrst_done", {31'b0, done}, 32'd0);
        check_val("midrst_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("postrst_done", {31'b0, done}, 32'd0);
        run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 34, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
